// File: rtl/esm_pkg.sv
// Shared types and defaults for the ESM issue scheduler.
// Slot record and buffer geometry used by the scheduler and its tests.
package esm_pkg;

    localparam int IW = 32;
    localparam int BS = 16;
    localparam int BS_BITS = $clog2(BS);
    localparam int SETTLE_DEF = 2;
    localparam int SET_BITS = $clog2(SETTLE_DEF + 1);

    typedef struct packed {
        logic                valid;
        logic                issued;
        logic [SET_BITS-1:0] settle;
        logic [IW-1:0]       instr;
    } slot_t;

endpackage

// File: rtl/esm_rr_picker.sv
// Round-robin first-set finder over an N-wide request mask.
// Scans from ptr+1 upward with wrap-around; ptr itself is checked last.
module esm_rr_picker #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);

    logic [W-1:0] idx;

    always_comb begin
        found = 1'b0;
        index = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ptr + W'(k);
            if (!found && mask[idx]) begin
                found = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/esm_issue_scheduler.sv
// Instruction buffer controller for ESM_Core_IDA: allocation, settle
// masking, round-robin issue and retirement of bs slots.
module esm_issue_scheduler
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = IW,
    parameter int bs = BS,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [Instruction_word_size-1:0] instr_in,
    input  logic                             regwrite_in,
    input  logic                             alusrc_in,
    output logic [$clog2(bs)-1:0]            ida_buffer_index,
    output logic [Instruction_word_size-1:0] ida_instr,
    output logic                             ida_regwrite,
    output logic                             ida_alusrc,
    output logic [0:bs-1]                    ida_valid_entries,
    input  logic [0:bs-1]                    independent_instr,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [$clog2(bs)-1:0]            issue_index,
    output logic [Instruction_word_size-1:0] issue_instr,
    input  logic                             done_valid,
    input  logic [$clog2(bs)-1:0]            done_index,
    output logic                             err
);

    localparam int BW = $clog2(bs);

    slot_t         slot_q [bs];
    logic [bs-1:0] free_v;
    logic [bs-1:0] elig_v;
    logic [bs-1:0] cand_v;
    logic [BW-1:0] alloc_idx;
    logic [BW-1:0] pick_idx;
    logic [BW-1:0] pick_ptr;
    logic [BW-1:0] rr_ptr;
    logic          alloc;
    logic          accept;
    logic          load;
    logic          pick_found;
    logic          done_ok;

    always_comb begin
        free_v = '0;
        elig_v = '0;
        ida_valid_entries = '0;
        for (int i = 0; i < bs; i++) begin
            free_v[i] = ~slot_q[i].valid;
            elig_v[i] = slot_q[i].valid & ~slot_q[i].issued
                      & (slot_q[i].settle == '0)
                      & independent_instr[i];
            ida_valid_entries[i] = slot_q[i].valid;
        end
    end

    assign in_ready = |free_v;
    assign alloc    = in_valid & in_ready;
    assign accept   = issue_valid & issue_ready;
    assign load     = ~issue_valid | issue_ready;
    assign done_ok  = slot_q[done_index].valid & slot_q[done_index].issued;

    always_comb begin
        alloc_idx = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (free_v[i]) alloc_idx = BW'(i);
        end
    end

    // The offered slot is not yet marked issued, so hide it from the
    // next pick; on acceptance the scan already starts after it.
    always_comb begin
        cand_v = elig_v;
        if (issue_valid) cand_v[issue_index] = 1'b0;
        pick_ptr = accept ? issue_index : rr_ptr;
    end

    esm_rr_picker #(
        .N(bs),
        .W(BW)
    ) u_pick (
        .mask (cand_v),
        .ptr  (pick_ptr),
        .found(pick_found),
        .index(pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < bs; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < bs; i++) begin
                if (slot_q[i].settle != '0)
                    slot_q[i].settle <= slot_q[i].settle - 1'b1;
            end
            if (alloc) begin
                slot_q[alloc_idx].valid  <= 1'b1;
                slot_q[alloc_idx].issued <= 1'b0;
                slot_q[alloc_idx].settle <= SET_BITS'(SETTLE);
                slot_q[alloc_idx].instr  <= instr_in;
            end
            if (accept) slot_q[issue_index].issued <= 1'b1;
            if (done_valid && done_ok) begin
                slot_q[done_index].valid  <= 1'b0;
                slot_q[done_index].issued <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_valid <= 1'b0;
            issue_index <= '0;
            issue_instr <= '0;
            rr_ptr      <= BW'(bs - 1);
        end else begin
            if (accept) rr_ptr <= issue_index;
            if (load) begin
                issue_valid <= pick_found;
                if (pick_found) begin
                    issue_index <= pick_idx;
                    issue_instr <= slot_q[pick_idx].instr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ida_buffer_index <= '0;
            ida_instr        <= '0;
            ida_regwrite     <= 1'b0;
            ida_alusrc       <= 1'b0;
        end else if (alloc) begin
            ida_buffer_index <= alloc_idx;
            ida_instr        <= instr_in;
            ida_regwrite     <= regwrite_in;
            ida_alusrc       <= alusrc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) err <= 1'b0;
        else if (done_valid && !done_ok) err <= 1'b1;
    end

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Scoreboard bench for esm_issue_scheduler: expected issues are queued
// as stimulus makes slots eligible and popped on each handshake.
module tb_esm_issue_scheduler;

    localparam int NB  = 16;
    localparam int BW  = 4;
    localparam int STL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instr_in = '0;
    logic          regwrite_in = 1'b0;
    logic          alusrc_in = 1'b0;
    logic [BW-1:0] ida_buffer_index;
    logic [31:0]   ida_instr;
    logic          ida_regwrite;
    logic          ida_alusrc;
    logic [0:NB-1] ida_valid_entries;
    logic [0:NB-1] independent_instr = '0;
    logic          issue_valid;
    logic          issue_ready = 1'b0;
    logic [BW-1:0] issue_index;
    logic [31:0]   issue_instr;
    logic          done_valid = 1'b0;
    logic [BW-1:0] done_index = '0;
    logic          err;

    always #5 clk = ~clk;

    esm_issue_scheduler #(
        .Instruction_word_size(32),
        .bs(NB),
        .SETTLE(STL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .instr_in(instr_in),
        .regwrite_in(regwrite_in),
        .alusrc_in(alusrc_in),
        .ida_buffer_index(ida_buffer_index),
        .ida_instr(ida_instr),
        .ida_regwrite(ida_regwrite),
        .ida_alusrc(ida_alusrc),
        .ida_valid_entries(ida_valid_entries),
        .independent_instr(independent_instr),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_index(issue_index),
        .issue_instr(issue_instr),
        .done_valid(done_valid),
        .done_index(done_index),
        .err(err)
    );

    typedef struct {
        int          idx;
        logic [31:0] w;
    } exp_t;

    exp_t        sb[$];
    logic        mvalid [NB];
    logic [31:0] mword [NB];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int low_free();
        for (int i = 0; i < NB; i++) if (!mvalid[i]) return i;
        return -1;
    endfunction

    function automatic logic [0:NB-1] mvec();
        logic [0:NB-1] v;
        for (int i = 0; i < NB; i++) v[i] = mvalid[i];
        return v;
    endfunction

    task automatic send(input logic [31:0] w, input logic rw,
                        input logic as);
        int n = 0;
        int e;
        in_valid = 1'b1;
        instr_in = w;
        regwrite_in = rw;
        alusrc_in = as;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", in_ready, 1);
        e = low_free();
        tick();
        in_valid = 1'b0;
        check("ida_index", ida_buffer_index, 64'(e));
        check("ida_instr", ida_instr, w);
        check("ida_regwrite", ida_regwrite, rw);
        check("ida_alusrc", ida_alusrc, as);
        if (e >= 0) begin
            mvalid[e] = 1'b1;
            mword[e] = w;
        end
    endtask

    task automatic done(input int idx);
        done_valid = 1'b1;
        done_index = BW'(idx);
        tick();
        done_valid = 1'b0;
    endtask

    task automatic push(input int idx);
        exp_t e;
        e.idx = idx;
        e.w = mword[idx];
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, output int n);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_issue_valid"}, issue_valid, 0);
        check({tag, "_issue_index"}, issue_index, 0);
        check({tag, "_issue_instr"}, issue_instr, 0);
        check({tag, "_ida_index"}, ida_buffer_index, 0);
        check({tag, "_ida_instr"}, ida_instr, 0);
        check({tag, "_ida_rw"}, ida_regwrite, 0);
        check({tag, "_ida_as"}, ida_alusrc, 0);
        check({tag, "_valid"}, ida_valid_entries, 0);
        check({tag, "_err"}, err, 0);
    endtask

    always @(negedge clk) begin
        if (rst && issue_valid && issue_ready) begin
            exp_t e;
            check("issue_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("issue_idx", issue_index, 64'(e.idx));
                check("issue_word", issue_instr, e.w);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        for (int i = 0; i < NB; i++) begin
            mvalid[i] = 1'b0;
            mword[i] = '0;
        end
        repeat (3) tick();
        check_reset("rst");
        rst = 1'b1;
        tick();

        // single instruction: write slot 0, issue after SETTLE+2 edges
        independent_instr = '1;
        send(32'h1234_5678, 1'b1, 1'b0);
        check("t1_valid", ida_valid_entries, mvec());
        lat = 1;
        while (!issue_valid && lat < 12) begin
            tick();
            lat++;
        end
        check("t1_latency", lat, STL + 2);
        check("t1_index", issue_index, 0);
        check("t1_instr", issue_instr, 32'h1234_5678);
        push(0);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("t1_issued", sb.size(), 0);
        independent_instr = '0;
        done(0);
        mvalid[0] = 1'b0;
        check("t1_err", err, 0);

        // fill all slots, then free slot 5
        for (int i = 0; i < NB; i++)
            send(32'hA000_0000 + 32'(i), i[0], i[1]);
        check("full_ready", in_ready, 0);
        check("full_valid", ida_valid_entries, 16'hFFFF);
        independent_instr[5] = 1'b1;
        push(5);
        issue_ready = 1'b1;
        drain("iss5", n);
        issue_ready = 1'b0;
        independent_instr = '0;
        done_valid = 1'b1;
        done_index = 4'd5;
        check("full_hold", in_ready, 0);
        tick();
        done_valid = 1'b0;
        mvalid[5] = 1'b0;
        check("freed_ready", in_ready, 1);
        send(32'hC0DE_0005, 1'b1, 1'b1);
        check("refill_err", err, 0);

        // dependency hold on slot 3
        independent_instr[4] = 1'b1;
        push(4);
        issue_ready = 1'b1;
        drain("iss4", n);
        repeat (6) tick();
        check("dep_hold", issue_valid, 0);
        independent_instr[3] = 1'b1;
        push(3);
        drain("iss3", n);
        check("dep_latency", n <= 2, 1);
        issue_ready = 1'b0;

        // backpressure, plus a completion on an unissued slot
        independent_instr[7] = 1'b1;
        independent_instr[12] = 1'b1;
        n = 0;
        while (!issue_valid && n < 8) begin
            tick();
            n++;
        end
        check("bp_valid", issue_valid, 1);
        check("bp_index", issue_index, 7);
        check("bp_instr", issue_instr, mword[7]);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                done_valid = 1'b1;
                done_index = 4'd12;
            end
            tick();
            done_valid = 1'b0;
            check("bp_hold_v", issue_valid, 1);
            check("bp_hold_i", issue_index, 7);
            check("bp_hold_w", issue_instr, mword[7]);
        end
        check("proto_err", err, 1);
        check("proto_state", ida_valid_entries, mvec());
        push(7);
        push(12);
        issue_ready = 1'b1;
        drain("bp_release", n);
        issue_ready = 1'b0;
        check("err_sticky", err, 1);

        // reset with a full buffer
        rst = 1'b0;
        tick();
        check_reset("midrst");
        independent_instr = '0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < NB; i++) mvalid[i] = 1'b0;
        tick();
        done(0);
        check("late_done_err", err, 1);
        rst = 1'b0;
        tick();
        check("err_cleared", err, 0);
        rst = 1'b1;
        tick();

        // round-robin over slots 0, 2, 9, then continuing after 9
        for (int i = 0; i < 12; i++)
            send(32'hB000_0000 + 32'(i), 1'b0, i[0]);
        repeat (STL + 1) tick();
        independent_instr[0] = 1'b1;
        independent_instr[2] = 1'b1;
        independent_instr[9] = 1'b1;
        push(0);
        push(2);
        push(9);
        issue_ready = 1'b1;
        drain("rr1", n);
        check("rr1_b2b", n, 4);
        issue_ready = 1'b0;
        independent_instr = '0;
        done(0);
        done(2);
        done(9);
        mvalid[0] = 1'b0;
        mvalid[2] = 1'b0;
        mvalid[9] = 1'b0;
        send(32'hD000_0000, 1'b1, 1'b0);
        send(32'hD000_0002, 1'b1, 1'b0);
        send(32'hD000_0009, 1'b1, 1'b0);
        repeat (STL + 1) tick();
        independent_instr[0] = 1'b1;
        independent_instr[2] = 1'b1;
        independent_instr[9] = 1'b1;
        independent_instr[11] = 1'b1;
        push(11);
        push(0);
        push(2);
        push(9);
        issue_ready = 1'b1;
        drain("rr2", n);
        check("rr2_b2b", n, 5);
        issue_ready = 1'b0;
        check("end_err", err, 0);
        check("end_valid", ida_valid_entries, mvec());

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
